// File: rtl/risc_v_soc.sv
// Single-cycle RV32I-subset SoC: one instruction retires per clock edge.
// Instruction and data memories read combinationally; data writes land on the edge.

module DualRamTemplate #(
    parameter int DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [31:0] i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_raddr,
    output logic [31:0] o_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   memory [0:DEPTH-1];
    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_ridx;
    logic          w_unusedAddrBits;

    // Byte address to word index; the upper bits simply fall away so accesses wrap.
    assign w_widx           = i_waddr[AW+1:2];
    assign w_ridx           = i_raddr[AW+1:2];
    assign w_unusedAddrBits = ^{i_waddr[31:AW+2], i_waddr[1:0], i_raddr[31:AW+2], i_raddr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            memory[w_widx] <= i_wdata;
        end
    end

    assign o_rdata = memory[w_ridx];
endmodule

module Mem32Bits #(
    parameter int DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [31:0] i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_raddr,
    output logic [31:0] o_rdata
);
    DualRamTemplate #(.DEPTH(DEPTH)) dual_ram_template_inst (
        .i_clk  (i_clk),
        .i_we   (i_we),
        .i_waddr(i_waddr),
        .i_wdata(i_wdata),
        .i_raddr(i_raddr),
        .o_rdata(o_rdata)
    );
endmodule

module InstrRom #(
    parameter int DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic [31:0] i_addr,
    output logic [31:0] o_rdata
);
    Mem32Bits #(.DEPTH(DEPTH)) rom_32bits (
        .i_clk  (i_clk),
        .i_we   (1'b0),
        .i_waddr(i_addr),
        .i_wdata(32'h0),
        .i_raddr(i_addr),
        .o_rdata(o_rdata)
    );
endmodule

module DataRam #(
    parameter int DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    Mem32Bits #(.DEPTH(DEPTH)) ram_32bits (
        .i_clk  (i_clk),
        .i_we   (i_we),
        .i_waddr(i_addr),
        .i_wdata(i_wdata),
        .i_raddr(i_addr),
        .o_rdata(o_rdata)
    );
endmodule

module risc_v_soc #(
    parameter int          ROM_DEPTH = 1024,
    parameter int          RAM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [31:0] w_instr, w_ramRdata, w_pcPlus4, w_rs1Val, w_rs2Val;
    logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ, w_dataAddr, w_jalrSum;
    logic [31:0] w_wbData, w_nextPc;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic        w_rLegal, w_iLegal, w_regWe, w_memWe;

    function automatic logic [31:0] aluOp(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic branchTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    InstrRom #(.DEPTH(ROM_DEPTH)) rom_inst (
        .i_clk  (clk),
        .i_addr (r_pc),
        .o_rdata(w_instr)
    );

    // The write enable is masked by reset so an edge seen during reset stores nothing.
    DataRam #(.DEPTH(RAM_DEPTH)) ram_inst (
        .i_clk  (clk),
        .i_we   (w_memWe & ~rst),
        .i_addr (w_dataAddr),
        .i_wdata(w_rs2Val),
        .o_rdata(w_ramRdata)
    );

    assign w_opcode  = w_instr[6:0];
    assign w_rd      = w_instr[11:7];
    assign w_funct3  = w_instr[14:12];
    assign w_rs1     = w_instr[19:15];
    assign w_rs2     = w_instr[24:20];
    assign w_funct7  = w_instr[31:25];
    assign w_immI    = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_immS    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_immB    = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_immU    = {w_instr[31:12], 12'b0};
    assign w_immJ    = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_rs1Val  = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
    assign w_rs2Val  = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];
    assign w_pcPlus4 = r_pc + 32'd4;
    assign w_dataAddr = w_rs1Val + ((w_opcode == OP_STORE) ? w_immS : w_immI);
    assign w_jalrSum = w_rs1Val + w_immI;

    // Only the funct7 patterns of real RV32I instructions decode; anything else is a NOP.
    assign w_rLegal = (w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
    assign w_iLegal = (w_funct3 == 3'b001) ? (w_funct7 == 7'b0000000) :
                      (w_funct3 == 3'b101) ? ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000)) : 1'b1;

    always_comb begin
        w_regWe  = 1'b0;
        w_memWe  = 1'b0;
        w_wbData = 32'h0;
        w_nextPc = w_pcPlus4;
        case (w_opcode)
            OP_R: if (w_rLegal) begin
                w_regWe  = 1'b1;
                w_wbData = aluOp(w_funct3, w_funct7[5], w_rs1Val, w_rs2Val);
            end
            OP_IMM: if (w_iLegal) begin
                w_regWe  = 1'b1;
                w_wbData = aluOp(w_funct3, (w_funct3 == 3'b101) && w_funct7[5], w_rs1Val, w_immI);
            end
            OP_LOAD: if (w_funct3 == 3'b010) begin
                w_regWe  = 1'b1;
                w_wbData = w_ramRdata;
            end
            OP_STORE: w_memWe = (w_funct3 == 3'b010);
            OP_LUI: begin
                w_regWe  = 1'b1;
                w_wbData = w_immU;
            end
            OP_AUIPC: begin
                w_regWe  = 1'b1;
                w_wbData = r_pc + w_immU;
            end
            OP_BRANCH: if (branchTaken(w_funct3, w_rs1Val, w_rs2Val)) begin
                w_nextPc = r_pc + w_immB;
            end
            OP_JAL: begin
                w_regWe  = 1'b1;
                w_wbData = w_pcPlus4;
                w_nextPc = r_pc + w_immJ;
            end
            OP_JALR: if (w_funct3 == 3'b000) begin
                w_regWe  = 1'b1;
                w_wbData = w_pcPlus4;
                w_nextPc = {w_jalrSum[31:1], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else begin
            r_pc <= w_nextPc;
            if (w_regWe && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_wbData;
            end
        end
    end
endmodule

// File: tb/tb_risc_v_soc.sv
// Self-checking bench for risc_v_soc: directed programs with literal expectations,
// then random programs compared every cycle against an instruction-level model.

module tb_risc_v_soc;
    localparam int          ROM_DEPTH = 1024;
    localparam int          RAM_DEPTH = 1024;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    bit   checkEn = 0;

    logic [31:0] mRom [ROM_DEPTH];
    logic [31:0] mRam [RAM_DEPTH];
    logic [31:0] mReg [32];
    logic [31:0] mPc;
    int          mLastIdx;
    bit          mLastValid = 0;

    risc_v_soc #(.ROM_DEPTH(ROM_DEPTH), .RAM_DEPTH(RAM_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dutReg(input int i);
        return dut.r_regs[i];
    endfunction

    function automatic logic [31:0] dutRam(input int i);
        return dut.ram_inst.ram_32bits.dual_ram_template_inst.memory[i];
    endfunction

    task automatic loadRom(input int i, input logic [31:0] w);
        dut.rom_inst.rom_32bits.dual_ram_template_inst.memory[i] <= w;
        mRom[i] = w;
    endtask

    task automatic loadRam(input int i, input logic [31:0] w);
        dut.ram_inst.ram_32bits.dual_ram_template_inst.memory[i] <= w;
        mRam[i] = w;
    endtask

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encI(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] encB(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] encJ(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [4:0] randReg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic int randOffset();
        if ($urandom_range(0, 3) == 0) return -($urandom_range(1, 16) * 4);
        return $urandom_range(1, 16) * 4;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        rd  = randReg();
        rs1 = randReg();
        rs2 = randReg();
        imm = $urandom();
        f3  = 3'($urandom_range(0, 7));
        f7  = ((f3 == 3'd0 || f3 == 3'd5) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 19))
            0, 1, 2, 3: return encR(f7, rs2, rs1, f3, rd, 7'h33);
            4, 5, 6, 7: begin
                if (f3 == 3'd1) imm = {25'b0, rs2};
                if (f3 == 3'd5) imm = {20'b0, f7, rs2};
                return encI(imm, rs1, f3, rd, 7'h13);
            end
            8:      return {imm[31:12], rd, 7'h37};
            9:      return {imm[31:12], rd, 7'h17};
            10, 11: return encI(imm, rs1, 3'b010, rd, 7'h03);
            12, 13: return encS(imm, rs2, rs1);
            14, 15: begin
                f3 = 3'($urandom_range(0, 5));
                if (f3 >= 3'd2) f3 = f3 + 3'd2;
                return encB(randOffset(), rs2, rs1, f3);
            end
            16:     return encJ(randOffset(), rd);
            17:     return encI($urandom_range(0, 2047), rs1, 3'b000, rd, 7'h67);
            18:     return $urandom();
            default: return encR(7'h01, rs2, rs1, f3, rd, 7'h33);
        endcase
    endfunction

    // Reference model: executes one instruction from the architectural rules.
    task automatic modelStep();
        logic [31:0] ins, a, b, res, nextPc, addr;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int          immI, immS, immB, immJ;
        bit          wr;
        ins    = mRom[(mPc >> 2) % ROM_DEPTH];
        op     = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        rd     = ins[11:7];
        a      = mReg[ins[19:15]];
        b      = mReg[ins[24:20]];
        immI   = $signed(ins[31:20]);
        immS   = $signed({ins[31:25], ins[11:7]});
        immB   = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        immJ   = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        wr     = 0;
        res    = 0;
        nextPc = mPc + 4;
        mLastValid = 0;
        case (op)
            7'h33: begin
                wr = 1;
                case ({f7, f3})
                    {7'h00, 3'd0}: res = a + b;
                    {7'h20, 3'd0}: res = a - b;
                    {7'h00, 3'd1}: res = a << b[4:0];
                    {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    {7'h00, 3'd3}: res = (a < b) ? 1 : 0;
                    {7'h00, 3'd4}: res = a ^ b;
                    {7'h00, 3'd5}: res = a >> b[4:0];
                    {7'h20, 3'd5}: res = $signed(a) >>> b[4:0];
                    {7'h00, 3'd6}: res = a | b;
                    {7'h00, 3'd7}: res = a & b;
                    default:       wr = 0;
                endcase
            end
            7'h13: begin
                wr = 1;
                case (f3)
                    3'd0: res = a + immI;
                    3'd2: res = ($signed(a) < immI) ? 1 : 0;
                    3'd3: res = (a < 32'(immI)) ? 1 : 0;
                    3'd4: res = a ^ immI;
                    3'd6: res = a | immI;
                    3'd7: res = a & immI;
                    3'd1: if (f7 == 7'h00) res = a << ins[24:20]; else wr = 0;
                    default: begin
                        if (f7 == 7'h00) res = a >> ins[24:20];
                        else if (f7 == 7'h20) res = $signed(a) >>> ins[24:20];
                        else wr = 0;
                    end
                endcase
            end
            7'h03: if (f3 == 3'd2) begin
                addr = a + immI;
                res  = mRam[(addr >> 2) % RAM_DEPTH];
                wr   = 1;
            end
            7'h23: if (f3 == 3'd2) begin
                addr       = a + immS;
                mLastIdx   = (addr >> 2) % RAM_DEPTH;
                mRam[mLastIdx] = b;
                mLastValid = 1;
            end
            7'h37: begin res = {ins[31:12], 12'h0}; wr = 1; end
            7'h17: begin res = mPc + {ins[31:12], 12'h0}; wr = 1; end
            7'h63: begin
                case (f3)
                    3'd0: if (a == b) nextPc = mPc + immB;
                    3'd1: if (a != b) nextPc = mPc + immB;
                    3'd4: if ($signed(a) < $signed(b)) nextPc = mPc + immB;
                    3'd5: if ($signed(a) >= $signed(b)) nextPc = mPc + immB;
                    3'd6: if (a < b) nextPc = mPc + immB;
                    3'd7: if (a >= b) nextPc = mPc + immB;
                    default: ;
                endcase
            end
            7'h6F: begin res = mPc + 4; wr = 1; nextPc = mPc + immJ; end
            7'h67: if (f3 == 3'd0) begin
                nextPc = (a + immI) & 32'hFFFF_FFFE;
                res    = mPc + 4;
                wr     = 1;
            end
            default: ;
        endcase
        if (wr && rd != 5'd0) mReg[rd] = res;
        mPc = nextPc;
    endtask

    task automatic modelReset();
        mPc = RESET_PC;
        for (int i = 0; i < 32; i++) mReg[i] = 32'h0;
        mLastValid = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else modelStep();
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("pc", dut.r_pc, mPc);
            for (int i = 1; i < 32; i++) checkOutput($sformatf("x%0d", i), dutReg(i), mReg[i]);
            if (mLastValid) checkOutput($sformatf("ram[%0d]", mLastIdx), dutRam(mLastIdx), mRam[mLastIdx]);
        end
    end

    task automatic clearMemories();
        for (int i = 0; i < ROM_DEPTH; i++) loadRom(i, 32'h0);
        for (int i = 0; i < RAM_DEPTH; i++) loadRam(i, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        clearMemories();
        loadRom(0,  encI(5, 0, 3'd0, 1, 7'h13));
        loadRom(1,  encI(-3, 0, 3'd0, 2, 7'h13));
        loadRom(2,  encR(7'h00, 2, 1, 3'd0, 3, 7'h33));
        loadRom(3,  encS(0, 3, 0));
        loadRom(4,  encI(4, 0, 3'd2, 4, 7'h03));
        loadRom(5,  encS(8, 4, 0));
        loadRom(6,  encI(7, 0, 3'd0, 0, 7'h13));
        loadRom(7,  encS(12, 0, 0));
        loadRom(8,  encI(1, 0, 3'd0, 1, 7'h13));
        loadRom(9,  encI(1, 0, 3'd0, 2, 7'h13));
        loadRom(10, encB(8, 2, 1, 3'd0));
        loadRom(11, encI(99, 0, 3'd0, 6, 7'h13));
        loadRom(12, encI(-1, 0, 3'd0, 1, 7'h13));
        loadRom(13, encR(7'h00, 2, 1, 3'd2, 3, 7'h33));
        loadRom(14, encR(7'h00, 2, 1, 3'd3, 4, 7'h33));
        loadRom(15, encS(16, 3, 0));
        loadRom(16, encS(20, 4, 0));
        loadRom(17, encJ(12, 5));
        loadRom(18, encI(1, 0, 3'd0, 7, 7'h13));
        loadRom(19, encI(2, 0, 3'd0, 7, 7'h13));
        loadRom(20, encI(4, 0, 3'd2, 8, 7'h03));
        loadRom(21, encS(24, 8, 0));
        loadRom(22, encI(24, 0, 3'd2, 9, 7'h03));
        loadRam(1, 32'h1234_5678);
        loadRam(3, 32'hDEAD_BEEF);
        loadRam(5, 32'hCAFE_F00D);
        @(negedge clk);
        checkOutput("resetPc", dut.r_pc, 32'h0);
        checkOutput("resetX1", dutReg(1), 32'h0);
        checkEn = 1;
        rst = 1'b0;

        applyStimulus(4);
        checkOutput("addSum", dutRam(0), 32'h0000_0002);
        applyStimulus(2);
        checkOutput("lwSwCopy", dutRam(2), 32'h1234_5678);

        // Reset pulse straddling the edge that would execute SW x0,12(x0).
        applyStimulus(1);
        #3 rst = 1'b1;
        #1;
        checkOutput("asyncResetPc", dut.r_pc, 32'h0);
        checkOutput("asyncResetX3", dutReg(3), 32'h0);
        #14 rst = 1'b0;
        checkOutput("abortedStore", dutRam(3), 32'hDEAD_BEEF);
        checkOutput("ramKeptWord0", dutRam(0), 32'h0000_0002);
        checkOutput("ramKeptWord2", dutRam(2), 32'h1234_5678);
        applyStimulus(1);
        checkOutput("restartPc", dut.r_pc, 32'h4);
        checkOutput("restartX1", dutReg(1), 32'h5);

        applyStimulus(30);
        checkOutput("x0Store", dutRam(3), 32'h0);
        checkOutput("sltStored", dutRam(4), 32'h1);
        checkOutput("sltuStored", dutRam(5), 32'h0);
        checkOutput("beqSkipped", dutReg(6), 32'h0);
        checkOutput("jalLink", dutReg(5), 32'h48);
        checkOutput("jalSkipped", dutReg(7), 32'h0);
        checkOutput("storeThenLoad", dutReg(9), 32'h1234_5678);
        checkOutput("negOne", dutReg(1), 32'hFFFF_FFFF);

        rst = 1'b1;
        for (int i = 0; i < 32; i++) loadRom(i, 32'h0);
        for (int i = 0; i < 4; i++) loadRom(i, encI(0, 0, 3'd0, 0, 7'h13));
        loadRom(4, encJ(12, 5));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(5);
        checkOutput("jalAt10Link", dutReg(5), 32'h14);
        checkOutput("jalAt10Pc", dut.r_pc, 32'h1C);

        rst = 1'b1;
        for (int i = 0; i < ROM_DEPTH; i++) loadRom(i, randInstr());
        for (int i = 0; i < RAM_DEPTH; i++) loadRam(i, $urandom());
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1500);
        #3 rst = 1'b1;
        #1 checkOutput("randAsyncPc", dut.r_pc, RESET_PC);
        #14 rst = 1'b0;
        applyStimulus(1500);
        @(negedge clk);
        checkEn = 0;
        for (int i = 0; i < RAM_DEPTH; i++) checkOutput($sformatf("finalRam[%0d]", i), dutRam(i), mRam[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/risc_v_soc.md
RISC_V_SOC -- requirements
Module: risc_v_soc

Interface
REQ-001 The block SHALL have parameter ROM_DEPTH, default 1024, meaning the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 1024, meaning the data memory depth in 32-bit words.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-004 Port clk: input, 1 bit, the single system clock; all state updates occur on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have no other ports; results are observable only through internal memory and register-file state.

Function
REQ-007 The block SHALL be a single-cycle RV32I-subset processor: each clk rising edge retires exactly one instruction.
REQ-008 Instruction memory SHALL be a 32-bit word array named memory, reachable as rom_inst.rom_32bits.dual_ram_template_inst.memory, so a bench can load it with $readmemh.
REQ-009 Data memory SHALL be a 32-bit word array named memory, reachable as ram_inst.ram_32bits.dual_ram_template_inst.memory, and SHALL be loadable by $readmemh.
REQ-010 Both memories SHALL read combinationally and be indexed by byte address bits [log2(DEPTH)+1:2].
- Address bits [1:0] are ignored.
- Upper address bits wrap modulo DEPTH.
REQ-011 Data memory writes SHALL occur on the clk rising edge and write the full word.
REQ-012 The register file SHALL hold 32 x 32-bit registers.
- x0 reads 0 always; writes to x0 are discarded.
- Two combinational read ports, one write port written on the rising edge.
REQ-013 Supported instructions:
- R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
- I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
- Other: LW, SW, LUI, AUIPC, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR.
REQ-014 Arithmetic SHALL be 32-bit two's complement with wrap-around and no overflow trap.
- Shift amount is operand[4:0].
- SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU compare unsigned.
REQ-015 Immediates SHALL be sign-extended per the RV32I I/S/B/U/J formats.
REQ-016 Next PC rules:
- Default: PC+4.
- Taken branch and JAL: PC+imm.
- JALR: (rs1+imm) with bit 0 cleared.
- JAL/JALR write PC+4 to rd; when rd==rs1, JALR uses the old rs1 value.
REQ-017 LW SHALL write the data-memory word to rd in the same cycle; SW SHALL write rs2 to memory at rs1+imm.
REQ-018 Any unsupported or illegal opcode SHALL execute as a NOP: PC+4, no register or memory write.
REQ-019 A load from an address written by the immediately preceding SW SHALL return the new value, since each write completes at the edge before the next read.

Reset
REQ-020 While rst=1, PC SHALL be RESET_PC and registers x1..x31 SHALL be 0, asynchronously and independent of clk.
REQ-021 Reset SHALL NOT clear instruction or data memory, so preloaded contents survive reset.
REQ-022 Deasserting rst mid-program SHALL cause the first rising edge afterwards to execute the instruction at RESET_PC.
REQ-023 Asserting rst mid-program SHALL abort the current instruction: no register write and no memory write on that edge.

Verification
REQ-024 ROM = ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SW x3,0(x0) -> after 4 cycles RAM[0] = 32'h0000_0002.
REQ-025 RAM[1] = 32'h1234_5678; LW x4,4(x0); SW x4,8(x0) -> RAM[2] = 32'h1234_5678 after 2 cycles.
REQ-026 Branch/JAL:
- x1=1, x2=1, BEQ x1,x2,+8 -> the instruction at PC+4 is skipped.
- JAL x5,+12 at PC 0x10 -> x5 = 0x14 and next PC = 0x1C.
REQ-027 Signed compare: x1=-1, x2=1; SLT x3,x1,x2 and SLTU x4,x1,x2; SW both -> stored values are 1 and 0 respectively.
REQ-028 ADDI x0,x0,7; SW x0,12(x0) -> RAM[3] = 0.
REQ-029 Reset mid-run:
- Assert rst for 15 ns between edges -> PC = 0 immediately.
- RAM contents are unchanged.
- Execution restarts from word 0 after release.
